instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port Clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port InValid, input, 1: request present.
REQ-004 SHALL have port InReady, output, 1: encoder can accept a request.
REQ-005 SHALL have port InOp, input, 5: mnemonic code; 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 xor, 6 sll, 7 srl, 8 slt, 9 jr, 10 mul, 11 addi, 12 lw, 13 sw, 14 sb, 15 lh, 16 lb, 17 sh, 18 j, 19 jal, 20 andi, 21 ori, 22 xori, 23 slti; 24-31 illegal.
REQ-006 SHALL have ports InRs, InRt, InRd and InShamt, each input, 5: register and shift-amount fields.
REQ-007 SHALL have port InImm, input, 26: imm16 in [15:0] for I-type, or jump target for j/jal.
REQ-008 SHALL have port OutValid, output, 1: head word valid.
REQ-009 SHALL have port OutReady, input, 1: consumer accepts the head word.
REQ-010 SHALL have port OutInstr, output, 32: encoded MIPS word at the head.
REQ-011 SHALL have port OutAddr, output, 32: byte address of the head word.
REQ-012 SHALL have port Count, output, 3: FIFO occupancy, 0-4.
REQ-013 SHALL have port ErrIllegal, output, 1: sticky illegal-op flag.

Function
REQ-014 SHALL accept a request at an edge where InValid && InReady; SHALL pop the head at an edge where OutValid && OutReady.
REQ-015 SHALL hold encoded words in a 4-entry FIFO; a word SHALL be visible on OutInstr with OutValid=1 the cycle after acceptance when the FIFO was empty (latency 1).
REQ-016 R-type encoding SHALL be 000000|rs|rt|rd|shamt|funct with funct: add 100000, sub 100010, and 100100, or 100101, nor 100111, xor 100110, slt 101010, sll 000000, srl 000010; for all of these except sll/srl, shamt SHALL be 0.
REQ-017 For sll/srl the rs field SHALL be 0; for jr the word SHALL be 000000|rs|0|0|0|001000.
REQ-018 mul SHALL encode as 011100|rs|rt|rd|00000|000010.
REQ-019 I-type encoding SHALL be op|rs|rt|InImm[15:0] with op: addi 001000, lw 100011, sw 101011, sb 101000, lh 100001, lb 100000, sh 101001, andi 001100, ori 001101, xori 001110, slti 001010.
REQ-020 j SHALL encode as 000010|InImm[25:0]; jal SHALL encode as 000011|InImm[25:0].
REQ-021 An illegal InOp SHALL be accepted (handshake completes) but SHALL NOT be written to the FIFO, and SHALL set ErrIllegal=1 until Reset.
REQ-022 OutAddr SHALL equal 4 x (words popped since reset), modulo 2^32.
REQ-023 InReady SHALL depend only on the current Count, with no pop lookahead: InReady=(Count<=3).
REQ-024 A simultaneous push and pop SHALL leave Count unchanged, and the FIFO order SHALL be preserved.
REQ-025 When OutValid=1 and OutReady=0, OutInstr and OutAddr SHALL hold stable.
REQ-026 Count, OutValid and InReady SHALL be registered or derived only from registered state; there SHALL be no combinational path from InValid to InReady or from OutReady to OutValid.

Reset
REQ-027 On Reset=1, regardless of the clock, the block SHALL immediately drive Count=0, OutValid=0, OutInstr=0, OutAddr=0, ErrIllegal=0 and InReady=1, and SHALL discard all FIFO contents.
REQ-028 Reset asserted mid-stream SHALL drop all queued words; after deassertion, the first pop SHALL report OutAddr=0.

Configuration
REQ-029 With INSTR_ENC_NOP_PAD_EN defined, each accepted j, jal or jr SHALL push two words: the encoded jump followed by a delay-slot NOP 0x00000000.
REQ-030 With INSTR_ENC_NOP_PAD_EN defined, InReady SHALL be (Count<=2) so that both words always fit.
REQ-031 With INSTR_ENC_NOP_PAD_EN undefined, no padding SHALL occur and REQ-023 SHALL apply.

Verification
REQ-032 add rs=1 rt=2 rd=3, OutReady=1 -> OutInstr=0x00221820 one cycle later, OutAddr=0.
REQ-033 lw rs=29 rt=8 imm=4, then sll rt=3 rd=2 shamt=4 -> 0x8FA80004 at OutAddr 0, then 0x00031100 at OutAddr 4.
REQ-034 OutReady=0 with 5 back-to-back requests -> Count=4 and InReady=0 after 4 acceptances; each held word is unchanged; draining yields FIFO order with OutAddr 0, 4, 8, 12.
REQ-035 InOp=27 -> handshake completes, Count unchanged, ErrIllegal=1 until Reset.
REQ-036 With INSTR_ENC_NOP_PAD_EN: j InImm=0x10 -> 0x08000010 then 0x00000000; with Count=3, InReady=0.
REQ-037 Reset pulse asserted with 3 words queued -> Count=0 and OutValid=0 at once; the next accepted word appears at OutAddr=0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: encodes mnemonic requests into 32-bit MIPS words and queues them in a
// 4-entry FIFO. The head word is presented with its byte address (4 x words popped).
// Illegal opcodes complete the handshake, are dropped, and raise a sticky error flag.
// Optional feature: define INSTR_ENC_NOP_PAD_EN to append a delay-slot NOP after j/jal/jr.
module instr_encoder (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [4:0]  InOp,
    input  logic [4:0]  InRs,
    input  logic [4:0]  InRt,
    input  logic [4:0]  InRd,
    input  logic [4:0]  InShamt,
    input  logic [25:0] InImm,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutInstr,
    output logic [31:0] OutAddr,
    output logic [2:0]  Count,
    output logic        ErrIllegal
);

`ifdef INSTR_ENC_NOP_PAD_EN
    // Keep room for a jump plus its delay-slot NOP.
    localparam logic [2:0] ReadyMax = 3'd2;
    localparam logic       PadEn    = 1'b1;
`else
    localparam logic [2:0] ReadyMax = 3'd3;
    localparam logic       PadEn    = 1'b0;
`endif

    logic [31:0] mem_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        enc_jump;
    logic        push;
    logic        pop;
    logic [2:0]  push_n;

    // Translate the request fields into a MIPS word.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        enc_jump  = 1'b0;
        unique case (InOp)
            5'd0:  enc_word = {6'h00, InRs, InRt, InRd, 5'd0, 6'h20};
            5'd1:  enc_word = {6'h00, InRs, InRt, InRd, 5'd0, 6'h22};
            5'd2:  enc_word = {6'h00, InRs, InRt, InRd, 5'd0, 6'h24};
            5'd3:  enc_word = {6'h00, InRs, InRt, InRd, 5'd0, 6'h25};
            5'd4:  enc_word = {6'h00, InRs, InRt, InRd, 5'd0, 6'h27};
            5'd5:  enc_word = {6'h00, InRs, InRt, InRd, 5'd0, 6'h26};
            5'd6:  enc_word = {6'h00, 5'd0, InRt, InRd, InShamt, 6'h00};
            5'd7:  enc_word = {6'h00, 5'd0, InRt, InRd, InShamt, 6'h02};
            5'd8:  enc_word = {6'h00, InRs, InRt, InRd, 5'd0, 6'h2a};
            5'd9: begin
                enc_word = {6'h00, InRs, 15'd0, 6'h08};
                enc_jump = 1'b1;
            end
            5'd10: enc_word = {6'h1c, InRs, InRt, InRd, 5'd0, 6'h02};
            5'd11: enc_word = {6'h08, InRs, InRt, InImm[15:0]};
            5'd12: enc_word = {6'h23, InRs, InRt, InImm[15:0]};
            5'd13: enc_word = {6'h2b, InRs, InRt, InImm[15:0]};
            5'd14: enc_word = {6'h28, InRs, InRt, InImm[15:0]};
            5'd15: enc_word = {6'h21, InRs, InRt, InImm[15:0]};
            5'd16: enc_word = {6'h20, InRs, InRt, InImm[15:0]};
            5'd17: enc_word = {6'h29, InRs, InRt, InImm[15:0]};
            5'd18: begin
                enc_word = {6'h02, InImm};
                enc_jump = 1'b1;
            end
            5'd19: begin
                enc_word = {6'h03, InImm};
                enc_jump = 1'b1;
            end
            5'd20: enc_word = {6'h0c, InRs, InRt, InImm[15:0]};
            5'd21: enc_word = {6'h0d, InRs, InRt, InImm[15:0]};
            5'd22: enc_word = {6'h0e, InRs, InRt, InImm[15:0]};
            5'd23: enc_word = {6'h0a, InRs, InRt, InImm[15:0]};
            default: enc_legal = 1'b0;
        endcase
    end

    // Handshakes and next-state for pointers, occupancy, address and error flag.
    always_comb begin
        InReady  = (count_q <= ReadyMax);
        OutValid = (count_q != 3'd0);
        push     = InValid && InReady;
        pop      = OutValid && OutReady;
        push_n   = 3'd0;
        if (push && enc_legal) begin
            push_n = (PadEn && enc_jump) ? 3'd2 : 3'd1;
        end
        wr_ptr_d = wr_ptr_q + push_n[1:0];
        rd_ptr_d = rd_ptr_q + {1'b0, pop};
        count_d  = count_q + push_n - {2'b00, pop};
        addr_d   = pop ? (addr_q + 32'd4) : addr_q;
        err_d    = err_q | (push && !enc_legal);
    end

    // Control state; reset discards the queue and clears the error flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    // FIFO storage; contents are don't-care while the slot is empty.
    always_ff @(posedge Clk) begin
        if (push_n != 3'd0) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
        if (push_n == 3'd2) begin
            mem_q[wr_ptr_q + 2'd1] <= 32'h0000_0000;
        end
    end

    // Head word is forced to zero when empty so reset shows 0 immediately.
    always_comb begin
        OutInstr   = OutValid ? mem_q[rd_ptr_q] : 32'h0;
        OutAddr    = addr_q;
        Count      = count_q;
        ErrIllegal = err_q;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder.
// Inputs change and outputs are sampled on the falling clock edge.
// Covers INSTR_ENC_NOP_PAD_EN when that macro is defined for the build.
module tb_instr_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [25:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic [2:0]  count;
    logic        err_illegal;

    int n_checks = 0;
    int n_errors = 0;

    instr_encoder dut (
        .Clk        (clk),
        .Reset      (reset),
        .InValid    (in_valid),
        .InReady    (in_ready),
        .InOp       (in_op),
        .InRs       (in_rs),
        .InRt       (in_rt),
        .InRd       (in_rd),
        .InShamt    (in_shamt),
        .InImm      (in_imm),
        .OutValid   (out_valid),
        .OutReady   (out_ready),
        .OutInstr   (out_instr),
        .OutAddr    (out_addr),
        .Count      (count),
        .ErrIllegal (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm);
        in_valid = 1'b1;
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_shamt = sh;
        in_imm   = imm;
    endtask

    // One-cycle request, called at a falling edge; returns at the next falling edge.
    task automatic push(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm);
        set_req(op, rs, rt, rd, sh, imm);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [25:0] imm;
        logic [31:0] word;
    } vec_t;

    vec_t fill_vec [5];
    vec_t enc_vec [8];

    initial begin
        fill_vec[0] = '{5'd1,  5'd4, 5'd5, 5'd6, 5'd5, 26'h0,      32'h0085_3022}; // sub
        fill_vec[1] = '{5'd2,  5'd7, 5'd8, 5'd9, 5'd0, 26'h0,      32'h00e8_4824}; // and
        fill_vec[2] = '{5'd21, 5'd2, 5'd3, 5'd0, 5'd0, 26'hbeef,   32'h3443_beef}; // ori
        fill_vec[3] = '{5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 26'h100,    32'h0c00_0100}; // jal
        fill_vec[4] = '{5'd11, 5'd0, 5'd1, 5'd0, 5'd0, 26'h1,      32'h2001_0001}; // addi

        enc_vec[0] = '{5'd9,  5'd31, 5'd7, 5'd7, 5'd3, 26'h0,       32'h03e0_0008}; // jr
        enc_vec[1] = '{5'd10, 5'd1,  5'd2, 5'd3, 5'd9, 26'h0,       32'h7022_1802}; // mul
        enc_vec[2] = '{5'd7,  5'd9,  5'd3, 5'd2, 5'd4, 26'h0,       32'h0003_1102}; // srl
        enc_vec[3] = '{5'd13, 5'd29, 5'd31, 5'd0, 5'd0, 26'hfffc,   32'hafbf_fffc}; // sw
        enc_vec[4] = '{5'd18, 5'd0,  5'd0, 5'd0, 5'd0, 26'h3ffffff, 32'h0bff_ffff}; // j
        enc_vec[5] = '{5'd4,  5'd1,  5'd2, 5'd3, 5'd0, 26'h0,       32'h0022_1827}; // nor
        enc_vec[6] = '{5'd23, 5'd1,  5'd2, 5'd0, 5'd0, 26'h8000,    32'h2822_8000}; // slti
        enc_vec[7] = '{5'd5,  5'd1,  5'd2, 5'd3, 5'd0, 26'h0,       32'h0022_1826}; // xor
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_req(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0);
        in_valid  = 1'b0;
        #2;
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_ovalid", {31'b0, out_valid}, 32'd0);
        check("rst_iready", {31'b0, in_ready}, 32'd1);
        check("rst_instr", out_instr, 32'h0);
        check("rst_addr", out_addr, 32'h0);
        check("rst_err", {31'b0, err_illegal}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // add with consumer ready: visible one cycle after acceptance.
        out_ready = 1'b1;
        push(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
        check("add_valid", {31'b0, out_valid}, 32'd1);
        check("add_instr", out_instr, 32'h0022_1820);
        check("add_addr", out_addr, 32'h0);
        @(negedge clk);
        check("add_popped_cnt", {29'b0, count}, 32'd0);
        check("add_popped_addr", out_addr, 32'd4);

`ifndef INSTR_ENC_NOP_PAD_EN
        // lw then sll, drained in order.
        do_reset();
        out_ready = 1'b0;
        push(5'd12, 5'd29, 5'd8, 5'd0, 5'd0, 26'h4);
        push(5'd6, 5'd17, 5'd3, 5'd2, 5'd4, 26'h0);
        check("lw_sll_cnt", {29'b0, count}, 32'd2);
        check("lw_instr", out_instr, 32'h8fa8_0004);
        check("lw_addr", out_addr, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        check("sll_instr", out_instr, 32'h0003_1100);
        check("sll_addr", out_addr, 32'd4);
        @(negedge clk);
        check("lw_sll_empty", {31'b0, out_valid}, 32'd0);
        check("lw_sll_addr", out_addr, 32'd8);

        // Fill to four with five back-to-back requests, hold, then drain.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(fill_vec[i].op, fill_vec[i].rs, fill_vec[i].rt, fill_vec[i].rd,
                    fill_vec[i].sh, fill_vec[i].imm);
            @(negedge clk);
        end
        check("full_cnt", {29'b0, count}, 32'd4);
        check("full_iready", {31'b0, in_ready}, 32'd0);
        check("full_hold_instr", out_instr, fill_vec[0].word);
        @(negedge clk);
        check("full_hold_cnt", {29'b0, count}, 32'd4);
        check("full_hold_instr2", out_instr, fill_vec[0].word);
        check("full_hold_addr", out_addr, 32'h0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_instr%0d", i), out_instr, fill_vec[i].word);
            check($sformatf("drain_addr%0d", i), out_addr, 32'(4 * i));
            @(negedge clk);
        end
        check("drain_empty", {31'b0, out_valid}, 32'd0);
        check("drain_iready", {31'b0, in_ready}, 32'd1);

        // Streaming push and pop each cycle: occupancy stays at one.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_req(enc_vec[i].op, enc_vec[i].rs, enc_vec[i].rt, enc_vec[i].rd,
                    enc_vec[i].sh, enc_vec[i].imm);
            @(negedge clk);
            check($sformatf("enc_instr%0d", i), out_instr, enc_vec[i].word);
            check($sformatf("enc_addr%0d", i), out_addr, 32'(4 * i));
            check($sformatf("enc_cnt%0d", i), {29'b0, count}, 32'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("enc_done_cnt", {29'b0, count}, 32'd0);

        // Illegal op: accepted, dropped, sticky error.
        do_reset();
        out_ready = 1'b0;
        push(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
        set_req(5'd27, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
        check("ill_iready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("ill_cnt", {29'b0, count}, 32'd1);
        check("ill_err", {31'b0, err_illegal}, 32'd1);
        check("ill_head", out_instr, 32'h0022_1820);
        @(negedge clk);
        @(negedge clk);
        check("ill_err_sticky", {31'b0, err_illegal}, 32'd1);
        do_reset();
        check("ill_err_cleared", {31'b0, err_illegal}, 32'd0);

        // Reset mid-stream with three queued and a nonzero address.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(fill_vec[i].op, fill_vec[i].rs, fill_vec[i].rt, fill_vec[i].rd,
                 fill_vec[i].sh, fill_vec[i].imm);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("mid_cnt", {29'b0, count}, 32'd3);
        check("mid_addr", out_addr, 32'd4);
        reset = 1'b1;
        #1;
        check("mid_rst_cnt", {29'b0, count}, 32'd0);
        check("mid_rst_ovalid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_addr", out_addr, 32'h0);
        check("mid_rst_instr", out_instr, 32'h0);
        check("mid_rst_iready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        push(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
        check("post_rst_cnt", {29'b0, count}, 32'd1);
        check("post_rst_instr", out_instr, 32'h0022_1826);
        check("post_rst_addr", out_addr, 32'h0);
`else
        // Jump padding: j pushes the jump and a NOP; three queued blocks input.
        do_reset();
        out_ready = 1'b0;
        push(5'd18, 5'd0, 5'd0, 5'd0, 5'd0, 26'h10);
        check("pad_cnt", {29'b0, count}, 32'd2);
        check("pad_instr", out_instr, 32'h0800_0010);
        check("pad_iready2", {31'b0, in_ready}, 32'd1);
        push(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
        check("pad_cnt3", {29'b0, count}, 32'd3);
        check("pad_iready3", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        check("pad_w0", out_instr, 32'h0800_0010);
        @(negedge clk);
        check("pad_w1", out_instr, 32'h0);
        check("pad_w1_valid", {31'b0, out_valid}, 32'd1);
        check("pad_w1_addr", out_addr, 32'd4);
        @(negedge clk);
        check("pad_w2", out_instr, 32'h0022_1820);
        check("pad_w2_addr", out_addr, 32'd8);
        @(negedge clk);
        check("pad_empty", {31'b0, out_valid}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
